// File: rtl/vote_link_peer.sv
// vote_link_peer: host-side endpoint of the voting controller word link.
// RTS/CTR handshake out, RTR/CTS handshake in, RX words buffered in a FIFO.
module vote_link_peer #(
  parameter int SYNC_STAGES = 2,
  parameter int RX_DEPTH    = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tx_valid,
  input  logic [3:0] tx_data,
  output logic       tx_ready,
  output logic       rts,
  output logic [3:0] v_in,
  input  logic       ctr,
  output logic       rtr,
  input  logic       cts,
  input  logic [3:0] v_out,
  output logic       rx_valid,
  output logic [3:0] rx_data,
  input  logic       rx_ready,
  output logic       tx_err,
  output logic [7:0] tx_count,
  output logic [7:0] rx_count
);

  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [TW-1:0] TMAX = TW'(TLIM);
  localparam int AW = $clog2(RX_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    TX_IDLE, TX_REQ, TX_RELEASE
  } tx_st_t;

  typedef enum logic [1:0] {
    RX_IDLE, RX_WAIT, RX_DROP
  } rx_st_t;

  logic       ctr_s;
  logic       cts_s;
  logic [3:0] v_out_s;

  if (SYNC_STAGES == 0) begin : g_direct
    assign ctr_s   = ctr;
    assign cts_s   = cts;
    assign v_out_s = v_out;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] ctr_q;
    logic [SYNC_STAGES-1:0] cts_q;
    logic [3:0]             vo_q [SYNC_STAGES];

    // v_out rides the same flop chain as cts so data and strobe line up
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        ctr_q <= '0;
        cts_q <= '0;
        for (int i = 0; i < SYNC_STAGES; i++)
          vo_q[i] <= '0;
      end else begin
        ctr_q[0] <= ctr;
        cts_q[0] <= cts;
        vo_q[0]  <= v_out;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          ctr_q[i] <= ctr_q[i-1];
          cts_q[i] <= cts_q[i-1];
          vo_q[i]  <= vo_q[i-1];
        end
      end
    end

    assign ctr_s   = ctr_q[SYNC_STAGES-1];
    assign cts_s   = cts_q[SYNC_STAGES-1];
    assign v_out_s = vo_q[SYNC_STAGES-1];
  end

  tx_st_t        tx_st;
  logic [TW-1:0] timer;
  logic          abort;

  // TX handshake: accept, raise rts, wait ctr (or time out), wait ctr low
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_st    <= TX_IDLE;
      tx_ready <= 1'b1;
      rts      <= 1'b0;
      v_in     <= '0;
      timer    <= '0;
      abort    <= 1'b0;
      tx_err   <= 1'b0;
      tx_count <= '0;
    end else begin
      unique case (tx_st)
        TX_IDLE: begin
          if (tx_valid) begin
            v_in     <= tx_data;
            rts      <= 1'b1;
            timer    <= '0;
            abort    <= 1'b0;
            tx_ready <= 1'b0;
            tx_st    <= TX_REQ;
          end
        end
        TX_REQ: begin
          timer <= timer + 1'b1;
          if (ctr_s) begin
            rts   <= 1'b0;
            tx_st <= TX_RELEASE;
          end else if (TIMEOUT != 0 && timer == TMAX) begin
            rts    <= 1'b0;
            tx_err <= 1'b1;
            abort  <= 1'b1;
            tx_st  <= TX_RELEASE;
          end
        end
        TX_RELEASE: begin
          if (!ctr_s) begin
            tx_ready <= 1'b1;
            tx_st    <= TX_IDLE;
            if (!abort)
              tx_count <= tx_count + 8'd1;
          end
        end
        default: tx_st <= TX_IDLE;
      endcase
    end
  end

  rx_st_t        rx_st;
  logic [3:0]    mem [RX_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] fcnt;
  logic          push;
  logic          pop;

  assign rx_valid = (fcnt != '0);
  assign rx_data  = rx_valid ? mem[rd_ptr] : 4'h0;
  assign push     = (rx_st == RX_WAIT) && cts_s;
  assign pop      = rx_valid && rx_ready;

  // RX handshake: offer rtr only when a slot is free, one push per cts phase
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_st    <= RX_IDLE;
      rtr      <= 1'b0;
      rx_count <= '0;
    end else begin
      unique case (rx_st)
        RX_IDLE: begin
          if (fcnt < CW'(RX_DEPTH)) begin
            rtr   <= 1'b1;
            rx_st <= RX_WAIT;
          end
        end
        RX_WAIT: begin
          if (cts_s) begin
            rtr      <= 1'b0;
            rx_count <= rx_count + 8'd1;
            rx_st    <= RX_DROP;
          end
        end
        RX_DROP: begin
          if (!cts_s)
            rx_st <= RX_IDLE;
        end
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fcnt <= fcnt + 1'b1;
        2'b01:   fcnt <= fcnt - 1'b1;
        default: fcnt <= fcnt;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= v_out_s;
  end

endmodule

// File: tb/tb_vote_link_peer.sv
// tb_vote_link_peer: randomized scoreboard bench for vote_link_peer.
// Controller behaviour is modelled by handshake responder processes.
module tb_vote_link_peer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [3:0] tx_data = '0;
  logic       tx_ready;
  logic       rts;
  logic [3:0] v_in;
  logic       ctr = 1'b0;
  logic       rtr;
  logic       cts = 1'b0;
  logic [3:0] v_out = '0;
  logic       rx_valid;
  logic [3:0] rx_data;
  logic       rx_ready = 1'b0;
  logic       tx_err;
  logic [7:0] tx_count;
  logic [7:0] rx_count;

  vote_link_peer #(
    .SYNC_STAGES(2),
    .RX_DEPTH(4),
    .TIMEOUT(64)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .rts(rts),
    .v_in(v_in),
    .ctr(ctr),
    .rtr(rtr),
    .cts(cts),
    .v_out(v_out),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rx_ready(rx_ready),
    .tx_err(tx_err),
    .tx_count(tx_count),
    .rx_count(rx_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [3:0] tx_q [$];
  logic [3:0] rx_exp [$];
  logic [3:0] send_q [$];
  logic [7:0] exp_tx_cnt = '0;
  logic [7:0] exp_rx_cnt = '0;
  bit         ctr_en = 1'b1;
  bit         ctr_pulse = 1'b0;
  bit         rx_en = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // controller side of TX: capture v_in when raising ctr, compare with queue
  initial begin
    int cnt = 0;
    int dly = 3;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        ctr = 1'b0;
        cnt = 0;
        tx_q.delete();
        exp_tx_cnt = '0;
      end else if (!ctr) begin
        if (ctr_pulse) begin
          ctr = 1'b1;
          cnt = 0;
        end else if (rts && ctr_en) begin
          cnt++;
          if (cnt >= dly) begin
            if (tx_q.size() == 0)
              check("tx_unexpected", 1, 0);
            else
              check("tx_word", int'(v_in), int'(tx_q.pop_front()));
            exp_tx_cnt = exp_tx_cnt + 8'd1;
            ctr = 1'b1;
            cnt = 0;
            dly = $urandom_range(1, 4);
          end
        end else begin
          cnt = 0;
        end
      end else if (!rts) begin
        cnt++;
        if (cnt >= 3) begin
          ctr = 1'b0;
          cnt = 0;
        end
      end
    end
  end

  // controller side of RX: send queued words when rtr is offered
  initial begin
    int cnt = 0;
    int dly = 1;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        cts = 1'b0;
        cnt = 0;
        rx_exp.delete();
        exp_rx_cnt = '0;
      end else if (!cts) begin
        if (rtr && rx_en && send_q.size() > 0) begin
          cnt++;
          if (cnt >= dly) begin
            v_out = send_q.pop_front();
            rx_exp.push_back(v_out);
            exp_rx_cnt = exp_rx_cnt + 8'd1;
            cts = 1'b1;
            cnt = 0;
            dly = $urandom_range(1, 3);
          end
        end else begin
          cnt = 0;
        end
      end else if (!rtr) begin
        cnt++;
        if (cnt >= dly) begin
          cts = 1'b0;
          cnt = 0;
        end
      end
    end
  end

  // RX monitor: every pop must deliver the oldest word sent
  initial begin
    forever begin
      @(negedge clock);
      #1;
      if (reset_n && rx_valid && rx_ready) begin
        if (rx_exp.size() == 0)
          check("rx_unexpected", 1, 0);
        else
          check("rx_word", int'(rx_data), int'(rx_exp.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end

  task automatic send_tx(input logic [3:0] d);
    int n = 0;
    tx_valid = 1'b1;
    tx_data  = d;
    while (!tx_ready && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (n >= 300)
      check("tx_accept_timeout", 0, 1);
    else
      tx_q.push_back(d);
    @(negedge clock);
    tx_valid = 1'b0;
  endtask

  task automatic wait_tx_idle();
    int n = 0;
    while (!(tx_ready && !rts && !ctr) && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (n >= 500)
      check("tx_idle_timeout", 0, 1);
  endtask

  task automatic wait_rx_done();
    int n = 0;
    rx_ready = 1'b1;
    while ((send_q.size() != 0 || cts || rx_exp.size() != 0) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 2000)
      check("rx_done_timeout", 0, 1);
    @(negedge clock);
    rx_ready = 1'b0;
  endtask

  task automatic wait_rx_count(input logic [7:0] target);
    int n = 0;
    while (rx_count != target && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (n >= 500)
      check("rx_count_timeout", int'(rx_count), int'(target));
  endtask

  initial begin
    int n;
    logic [7:0] base;
    repeat (3) @(negedge clock);
    check("rst_rts", int'(rts), 0);
    check("rst_rtr", int'(rtr), 0);
    check("rst_v_in", int'(v_in), 0);
    check("rst_tx_err", int'(tx_err), 0);
    check("rst_tx_count", int'(tx_count), 0);
    check("rst_rx_count", int'(rx_count), 0);
    check("rst_rx_valid", int'(rx_valid), 0);
    check("rst_rx_data", int'(rx_data), 0);
    check("rst_tx_ready", int'(tx_ready), 1);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // single TX word with fixed controller delay of 3
    send_tx(4'hA);
    n = 0;
    while (rts && n < 50) begin
      check("t1_v_in_stable", int'(v_in), 'hA);
      n++;
      @(negedge clock);
    end
    check("t1_rts_high_cycles", n, 5);
    wait_tx_idle();
    check("t1_tx_count", int'(tx_count), 1);
    check("t1_tx_ready", int'(tx_ready), 1);

    // RX fills FIFO, fifth word waits for space
    base = rx_count;
    rx_ready = 1'b0;
    send_q.push_back(4'h5);
    send_q.push_back(4'h3);
    send_q.push_back(4'hC);
    send_q.push_back(4'h9);
    send_q.push_back(4'h1);
    wait_rx_count(base + 8'd4);
    repeat (12) @(negedge clock);
    check("t2_rtr_full", int'(rtr), 0);
    check("t2_rx_count4", int'(rx_count), int'(base + 8'd4));
    check("t2_rx_valid", int'(rx_valid), 1);
    check("t2_head", int'(rx_data), 'h5);
    rx_ready = 1'b1;
    @(negedge clock);
    rx_ready = 1'b0;
    wait_rx_count(base + 8'd5);
    check("t2_rx_count5", int'(rx_count), int'(base + 8'd5));
    wait_rx_done();
    check("t2_rx_empty", int'(rx_valid), 0);

    // TX timeout with no ctr, then a late ctr pulse
    base = tx_count;
    ctr_en = 1'b0;
    send_tx(4'h6);
    n = 0;
    while (rts && n < 200) begin
      n++;
      @(negedge clock);
    end
    check("t3_req_cycles", n, 64);
    check("t3_tx_err", int'(tx_err), 1);
    check("t3_tx_count", int'(tx_count), int'(base));
    void'(tx_q.pop_front());
    ctr_pulse = 1'b1;
    repeat (2) @(negedge clock);
    ctr_pulse = 1'b0;
    repeat (12) @(negedge clock);
    check("t3_idle", int'(tx_ready), 1);
    check("t3_err_sticky", int'(tx_err), 1);
    check("t3_count_after", int'(tx_count), int'(base));
    ctr_en = 1'b1;

    // random traffic, both directions, FIFO wraps with push/pop overlap
    rx_ready = 1'b0;
    base = rx_count;
    send_q.push_back(4'($urandom));
    send_q.push_back(4'($urandom));
    wait_rx_count(base + 8'd2);
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clock);
          send_tx(4'($urandom));
        end
      end
      begin
        for (int i = 0; i < 24; i++)
          send_q.push_back(4'($urandom));
      end
      begin
        for (int i = 0; i < 400; i++) begin
          @(negedge clock);
          rx_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    wait_tx_idle();
    wait_rx_done();
    check("t4_tx_count", int'(tx_count), int'(exp_tx_cnt));
    check("t4_rx_count", int'(rx_count), int'(exp_rx_cnt));
    check("t4_rx_empty", int'(rx_valid), 0);

    // concurrent single TX and RX
    base = tx_count;
    n = int'(rx_count);
    send_q.push_back(4'hE);
    send_tx(4'h7);
    wait_tx_idle();
    wait_rx_done();
    check("t5_tx_count", int'(tx_count), int'(base + 8'd1));
    check("t5_rx_count", int'(rx_count), int'(8'(n + 1)));

    // async reset mid-handshake
    ctr_en = 1'b0;
    rx_en = 1'b0;
    send_tx(4'h3);
    repeat (3) @(negedge clock);
    check("t6_pre_rts", int'(rts), 1);
    check("t6_pre_rtr", int'(rtr), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rts", int'(rts), 0);
    check("t6_rtr", int'(rtr), 0);
    check("t6_rx_valid", int'(rx_valid), 0);
    check("t6_tx_count", int'(tx_count), 0);
    check("t6_rx_count", int'(rx_count), 0);
    check("t6_tx_err", int'(tx_err), 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    ctr_en = 1'b1;
    rx_en = 1'b1;
    @(negedge clock);
    send_q.push_back(4'hD);
    send_tx(4'hB);
    wait_tx_idle();
    wait_rx_done();
    check("t6_post_tx_count", int'(tx_count), 1);
    check("t6_post_rx_count", int'(rx_count), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
